// File: rtl/controle_placar_if.sv
// Scoreboard control bus: point buttons, mode selects and score/indicator outputs.
interface controle_placar_if;
  logic       A;
  logic       B;
  logic       C;
  logic       ChaveNegativaPositiva;
  logic       MudarTime;
  logic       zerar;
  logic [6:0] pontos_time0;
  logic [6:0] pontos_time1;
  logic       buzzer;
  logic       led;
  logic       ocupado;

  modport master (
    output A, B, C, ChaveNegativaPositiva, MudarTime, zerar,
    input  pontos_time0, pontos_time1, buzzer, led, ocupado
  );

  modport slave (
    input  A, B, C, ChaveNegativaPositiva, MudarTime, zerar,
    output pontos_time0, pontos_time1, buzzer, led, ocupado
  );
endinterface

// File: rtl/controle_placar.sv
// Scoreboard sequencer: synchronises and debounces the point buttons, validates
// each accepted press against the selected team's score and commits exactly one
// add/subtract per press. Illegal requests pulse the buzzer instead.
module controle_placar #(
  parameter int DEB_CYCLES  = 4,
  parameter int BUZZ_CYCLES = 8,
  parameter int MAX_PONTOS  = 99
) (
  input  logic               clk,
  input  logic               rst,
  controle_placar_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB     = 2'd1,
    APPLY   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_CYCLES - 1);
  localparam logic [7:0] MAX8      = 8'(MAX_PONTOS);

  // Point value of a one-hot button code; zero marks an invalid combination.
  function automatic logic [1:0] valor_ponto(input logic [2:0] code);
    logic [1:0] v;
    case (code)
      3'b001:  v = 2'd1;
      3'b010:  v = 2'd2;
      3'b100:  v = 2'd3;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  logic [2:0] sync1_r, sync2_r, cap_r, cap_s;
  logic [2:0] code_s;
  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [6:0] t0_r, t1_r;
  logic [7:0] buzz_cnt_r;
  logic       buzzer_r, led_r, ocupado_r;

  logic [1:0] val_s;
  logic [6:0] sel_s, res_s;
  logic [7:0] sum_s;
  logic       valid_s, apply_s;

  assign code_s = sync2_r;
  assign apply_s = (state_r == APPLY);

  // Two-flop synchroniser for the asynchronous buttons, packed as {C,B,A}.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= {bus.C, bus.B, bus.A};
      sync2_r <= sync1_r;
    end
  end

  // FSM state, debounce counter and captured code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      cap_r   <= 3'b000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cap_r   <= cap_s;
    end
  end

  // Next-state logic: debounce press, single apply, then debounce release.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cap_s   = cap_r;
    case (state_r)
      IDLE: begin
        if (code_s != 3'b000) begin
          state_s = DEB;
          cap_s   = code_s;
          cnt_s   = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      DEB: begin
        if (code_s != cap_r) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else if (cnt_r == DEB_LAST) begin
          state_s = APPLY;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      APPLY: begin
        state_s = RELEASE;
        cnt_s   = 8'd0;
      end
      RELEASE: begin
        if (code_s != 3'b000) begin
          cnt_s = 8'd0;
        end else if (cnt_r == DEB_LAST) begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Evaluate the captured press against the selected team's score (8-bit sum).
  always_comb begin
    val_s   = valor_ponto(cap_r);
    sel_s   = bus.MudarTime ? t1_r : t0_r;
    sum_s   = {1'b0, sel_s} + {6'd0, val_s};
    res_s   = sel_s;
    valid_s = 1'b0;
    if (val_s == 2'd0) begin
      valid_s = 1'b0;
    end else if (bus.ChaveNegativaPositiva) begin
      valid_s = ({5'd0, val_s} <= sel_s);
      res_s   = sel_s - {5'd0, val_s};
    end else begin
      valid_s = (sum_s <= MAX8);
      res_s   = sum_s[6:0];
    end
  end

  // Score registers: clear has priority over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      t0_r <= 7'd0;
      t1_r <= 7'd0;
    end else if (bus.zerar) begin
      t0_r <= 7'd0;
      t1_r <= 7'd0;
    end else if (apply_s && valid_s) begin
      if (bus.MudarTime) begin
        t1_r <= res_s;
      end else begin
        t0_r <= res_s;
      end
    end else begin
      t0_r <= t0_r;
      t1_r <= t1_r;
    end
  end

  // Indicator outputs: commit pulse, buzzer timer and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r      <= 1'b0;
      buzzer_r   <= 1'b0;
      buzz_cnt_r <= 8'd0;
      ocupado_r  <= 1'b0;
    end else begin
      led_r     <= apply_s && valid_s && !bus.zerar;
      ocupado_r <= (state_s != IDLE);
      if (apply_s && !valid_s && !bus.zerar) begin
        buzz_cnt_r <= BUZZ_LAST;
        buzzer_r   <= 1'b1;
      end else if (buzz_cnt_r != 8'd0) begin
        buzz_cnt_r <= buzz_cnt_r - 8'd1;
        buzzer_r   <= 1'b1;
      end else begin
        buzz_cnt_r <= 8'd0;
        buzzer_r   <= 1'b0;
      end
    end
  end

  assign bus.pontos_time0 = t0_r;
  assign bus.pontos_time1 = t1_r;
  assign bus.buzzer       = buzzer_r;
  assign bus.led          = led_r;
  assign bus.ocupado      = ocupado_r;

endmodule

// File: tb/tb_controle_placar.sv
// Self-checking bench for controle_placar: vector table, directed corner
// sequences and randomized presses against a score-level reference model.
module tb_controle_placar;

  logic clk = 1'b0;
  logic rst;
  controle_placar_if bus();

  controle_placar #(.DEB_CYCLES(4), .BUZZ_CYCLES(8), .MAX_PONTOS(99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int led_tot = 0;
  int buzz_tot = 0;

  // Running totals of led pulses and buzzer-high cycles, sampled mid-cycle.
  always @(negedge clk) begin
    led_tot  += int'(bus.led);
    buzz_tot += int'(bus.buzzer);
  end

  typedef struct {
    logic [2:0] code;
    logic       team;
    logic       sub;
    int         hold;
    int         t0;
    int         t1;
    int         led;
    int         buzz;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_code(input logic [2:0] c);
    bus.A = c[0];
    bus.B = c[1];
    bus.C = c[2];
  endtask

  task automatic press(input logic [2:0] c, input logic team, input logic sub,
                       input int hold, input int gap);
    bus.MudarTime = team;
    bus.ChaveNegativaPositiva = sub;
    set_code(c);
    cycles(hold);
    set_code(3'b000);
    cycles(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_code(3'b000);
    bus.zerar = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  int l0, b0;
  int m0, m1, val, s, exp_led;
  logic [2:0] rc;
  logic rteam, rsub, rlong;
  int rhold;

  initial begin
    rst = 1'b1;
    bus.A = 1'b0; bus.B = 1'b0; bus.C = 1'b0;
    bus.ChaveNegativaPositiva = 1'b0;
    bus.MudarTime = 1'b0;
    bus.zerar = 1'b0;

    //             code    team  sub  hold t0 t1 led buzz
    tbl[0]  = '{3'b010, 1'b0, 1'b0, 8, 2, 0, 1, 0};
    tbl[1]  = '{3'b100, 1'b1, 1'b0, 8, 2, 3, 1, 0};
    tbl[2]  = '{3'b001, 1'b1, 1'b1, 8, 2, 2, 1, 0};
    tbl[3]  = '{3'b100, 1'b1, 1'b1, 8, 2, 2, 0, 8};
    tbl[4]  = '{3'b101, 1'b0, 1'b0, 8, 2, 2, 0, 8};
    tbl[5]  = '{3'b010, 1'b0, 1'b1, 8, 0, 2, 1, 0};
    tbl[6]  = '{3'b001, 1'b0, 1'b1, 8, 0, 2, 0, 8};
    tbl[7]  = '{3'b011, 1'b1, 1'b0, 8, 0, 2, 0, 8};
    tbl[8]  = '{3'b001, 1'b0, 1'b0, 3, 0, 2, 0, 0};
    tbl[9]  = '{3'b111, 1'b1, 1'b0, 8, 0, 2, 0, 8};
    tbl[10] = '{3'b001, 1'b1, 1'b0, 8, 0, 3, 1, 0};

    // Reset state
    do_reset();
    check("reset_t0", int'(bus.pontos_time0), 0);
    check("reset_t1", int'(bus.pontos_time1), 0);
    check("reset_buzzer", int'(bus.buzzer), 0);
    check("reset_led", int'(bus.led), 0);
    check("reset_ocupado", int'(bus.ocupado), 0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      l0 = led_tot;
      b0 = buzz_tot;
      press(tbl[i].code, tbl[i].team, tbl[i].sub, tbl[i].hold, 12);
      check($sformatf("tbl%0d_t0", i), int'(bus.pontos_time0), tbl[i].t0);
      check($sformatf("tbl%0d_t1", i), int'(bus.pontos_time1), tbl[i].t1);
      check($sformatf("tbl%0d_led", i), led_tot - l0, tbl[i].led);
      check($sformatf("tbl%0d_buzz", i), buzz_tot - b0, tbl[i].buzz);
    end

    // Latency: B held 20 cycles, score appears on the 8th edge after it is applied
    do_reset();
    l0 = led_tot;
    bus.MudarTime = 1'b0;
    bus.ChaveNegativaPositiva = 1'b0;
    set_code(3'b010);
    cycles(7);
    check("lat_before", int'(bus.pontos_time0), 0);
    check("lat_busy", int'(bus.ocupado), 1);
    cycles(1);
    check("lat_after", int'(bus.pontos_time0), 2);
    check("lat_led", int'(bus.led), 1);
    cycles(12);
    set_code(3'b000);
    cycles(12);
    check("lat_led_count", led_tot - l0, 1);
    check("lat_t1", int'(bus.pontos_time1), 0);
    check("lat_idle", int'(bus.ocupado), 0);

    // Bounce: A high 2, low 1, high 10 gives one +1
    l0 = led_tot;
    set_code(3'b001); cycles(2);
    set_code(3'b000); cycles(1);
    set_code(3'b001); cycles(10);
    set_code(3'b000); cycles(12);
    check("bounce_t0", int'(bus.pontos_time0), 3);
    check("bounce_led", led_tot - l0, 1);

    // Invalid subtract: buzzer exactly 8 cycles
    do_reset();
    press(3'b001, 1'b1, 1'b0, 8, 12);
    l0 = led_tot;
    bus.ChaveNegativaPositiva = 1'b1;
    set_code(3'b100);
    cycles(7);
    check("buzz_pre", int'(bus.buzzer), 0);
    cycles(1);
    check("buzz_start", int'(bus.buzzer), 1);
    cycles(7);
    check("buzz_last", int'(bus.buzzer), 1);
    cycles(1);
    check("buzz_end", int'(bus.buzzer), 0);
    set_code(3'b000);
    cycles(10);
    check("buzz_t1", int'(bus.pontos_time1), 1);
    check("buzz_led", led_tot - l0, 0);

    // Upper boundary: 98 + 2 rejected, 98 + 1 accepted, 99 + 1 rejected
    do_reset();
    for (int i = 0; i < 49; i++) press(3'b010, 1'b0, 1'b0, 8, 8);
    check("max_98", int'(bus.pontos_time0), 98);
    b0 = buzz_tot;
    press(3'b010, 1'b0, 1'b0, 8, 8);
    check("max_reject_t0", int'(bus.pontos_time0), 98);
    check("max_reject_buzz", buzz_tot - b0, 8);
    l0 = led_tot;
    press(3'b001, 1'b0, 1'b0, 8, 8);
    check("max_99", int'(bus.pontos_time0), 99);
    check("max_99_led", led_tot - l0, 1);
    b0 = buzz_tot;
    press(3'b001, 1'b0, 1'b0, 8, 8);
    check("max_over_t0", int'(bus.pontos_time0), 99);
    check("max_over_buzz", buzz_tot - b0, 8);

    // Reset during debounce aborts the pending update
    do_reset();
    press(3'b001, 1'b0, 1'b0, 8, 8);
    l0 = led_tot;
    bus.ChaveNegativaPositiva = 1'b0;
    set_code(3'b010);
    cycles(4);
    rst = 1'b1;
    set_code(3'b000);
    cycles(1);
    rst = 1'b0;
    check("rstdeb_t0", int'(bus.pontos_time0), 0);
    check("rstdeb_idle", int'(bus.ocupado), 0);
    cycles(15);
    check("rstdeb_t0_late", int'(bus.pontos_time0), 0);
    check("rstdeb_led", led_tot - l0, 0);

    // zerar coinciding with a valid APPLY
    press(3'b001, 1'b0, 1'b0, 8, 8);
    press(3'b100, 1'b1, 1'b0, 8, 8);
    check("zer_pre_t1", int'(bus.pontos_time1), 3);
    l0 = led_tot;
    b0 = buzz_tot;
    bus.MudarTime = 1'b0;
    set_code(3'b010);
    cycles(7);
    bus.zerar = 1'b1;
    cycles(1);
    bus.zerar = 1'b0;
    check("zer_t0", int'(bus.pontos_time0), 0);
    check("zer_t1", int'(bus.pontos_time1), 0);
    check("zer_led_now", int'(bus.led), 0);
    check("zer_busy", int'(bus.ocupado), 1);
    set_code(3'b000);
    cycles(12);
    check("zer_led", led_tot - l0, 0);
    check("zer_buzz", buzz_tot - b0, 0);

    // zerar coinciding with an invalid APPLY: no buzzer
    b0 = buzz_tot;
    set_code(3'b011);
    cycles(7);
    bus.zerar = 1'b1;
    cycles(1);
    bus.zerar = 1'b0;
    set_code(3'b000);
    cycles(12);
    check("zer_inv_buzz", buzz_tot - b0, 0);

    // Randomized presses against a score-level model
    do_reset();
    m0 = 0;
    m1 = 0;
    for (int i = 0; i < 40; i++) begin
      rc    = 3'($urandom_range(1, 7));
      rteam = 1'($urandom_range(0, 1));
      rsub  = ($urandom_range(0, 3) == 0);
      rlong = ($urandom_range(0, 3) != 0);
      rhold = rlong ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 3));
      l0 = led_tot;
      press(rc, rteam, rsub, rhold, 5);
      exp_led = 0;
      if (rlong) begin
        val = (rc == 3'b001) ? 1 : (rc == 3'b010) ? 2 : (rc == 3'b100) ? 3 : 0;
        s = rteam ? m1 : m0;
        if (val != 0) begin
          if (rsub && val <= s) begin
            s = s - val;
            exp_led = 1;
          end else if (!rsub && s + val <= 99) begin
            s = s + val;
            exp_led = 1;
          end
        end
        if (rteam) m1 = s; else m0 = s;
      end
      check($sformatf("rnd%0d_led", i), led_tot - l0, exp_led);
      if ($urandom_range(0, 9) == 0) begin
        bus.zerar = 1'b1;
        cycles(1);
        bus.zerar = 1'b0;
        m0 = 0;
        m1 = 0;
      end
      cycles(7);
      check($sformatf("rnd%0d_t0", i), int'(bus.pontos_time0), m0);
      check($sformatf("rnd%0d_t1", i), int'(bus.pontos_time1), m1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
